fir_linebuf_ctrl: RTL and testbench
===================================

Name: fir_linebuf_ctrl

Overview:
Sequencer for the 5x5 FIR line-buffer stage: four 2000-deep line BRAMs plus the live row. It derives the line and frame geometry from dv_i/hs_i/vs_i and generates bank write-enables, addresses, the row-rotation select and the border flags. After the last active line it runs two synthetic padding lines, so the bottom two kernel centre rows are emitted. It sits between the video input timing and the line-buffer/kernel datapath.

Parameters:
ADDR_W, 11, width of column/address counters
MAX_W, 2000, maximum active pixels per line; the column counter saturates at MAX_W-1
FLUSH_LINES, 2, synthetic lines generated after frame end (kernel radius)
HBLANK, 16, idle cycles inserted after each synthetic line

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
dv_i  in  1  input pixel valid
hs_i  in  1  line sync; rising edge = new line
vs_i  in  1  frame sync; rising edge = new frame / end of previous frame
wr_en  out  4  one-hot bank write enable
wr_addr  out  ADDR_W  bank write address (column)
rd_addr  out  ADDR_W  bank read address (column, same as wr_addr)
rot_sel  out  2  row-rotation select = row_cnt mod 4
pix_valid  out  1  datapath pixel strobe (dv_i or synthetic pixel)
pad_o  out  1  current pixel is synthetic; datapath muxes in 0
win_valid  out  1  5-row window is complete for this column
top_o, bot_o, left_o, right_o  out  1 each  centre pixel lies within 2 of that edge
row_idx  out  ADDR_W  input row counter
line_len  out  ADDR_W  last measured active width
overrun_o  out  1  sticky: dv_i seen during FLUSH

Behaviour:
- All outputs are registered, with 1-cycle latency from the sampled inputs. Reset values: all outputs 0, FSM in IDLE, line_len 0.
- Edge detect: hs_i and vs_i are each delayed by one register; a rising edge is sync & ~sync_dly.
- FSM IDLE: ignores dv_i and hs_i. Goes to ACTIVE on a vs edge, clearing row_cnt, col_cnt and overrun_o.
- FSM ACTIVE:
  - Each dv_i cycle: pix_valid=1, wr_en = 1<<(row_cnt mod 4), wr_addr = rd_addr = col_cnt, then col_cnt++ (saturating).
  - hs edge: if col_cnt>0, line_len <= col_cnt and row_cnt++. col_cnt <= 0 in either case. A line with zero dv_i does not advance the row.
  - vs edge: goes to FLUSH if row_cnt>=1, else stays in ACTIVE and restarts the frame.
  - If a vs edge and an hs edge coincide, vs wins: row_cnt is closed as above, then FLUSH.
- FSM FLUSH:
  - Generates FLUSH_LINES lines, each of line_len synthetic pixels (pix_valid=1, pad_o=1, wr_en one-hot as for a real row), followed by HBLANK idle cycles, with row_cnt++ per line.
  - After the last line goes to ACTIVE with row_cnt, col_cnt cleared (new frame already started by the vs edge).
  - If line_len=0, goes directly to ACTIVE.
  - dv_i=1 in FLUSH: overrun_o <= 1 (sticky until next frame), flush aborted, counters cleared, back to ACTIVE. That dv_i pixel is dropped.
- Window and flags, computed for the centre row = row_cnt-2, centre column = col_cnt:
  - win_valid = pix_valid & (row_cnt>=2).
  - top_o = centre row < 2.
  - bot_o = pad_o | (centre row >= H-2), where H is the real row count, latched on entry to FLUSH; bot_o is only required to be valid in FLUSH.
  - left_o = col_cnt < 2.
  - right_o = col_cnt >= line_len-2, using the previous line's line_len; for the first line of a frame right_o=0.
- rot_sel = row_cnt mod 4 during both ACTIVE and FLUSH.
- Reset mid-frame: same as power-up reset; the next vs edge is needed before any output becomes active.

Test Plan:
- Reset, then 3 lines of 8 dv pixels with no vs edge -> wr_en, pix_valid and win_valid stay 0 (IDLE).
- vs edge, 6 lines of 8 pixels, then vs edge:
  - row 0 writes with wr_en=0001, addr 0..7; row 5 writes with wr_en=0010.
  - line_len=8.
  - win_valid first asserts on row 2, col 0, with top_o=1 and left_o=1.
- Continue the same frame into FLUSH -> 2 synthetic lines of 8 pixels, pad_o=1, bot_o=1, wr_en=0100 then 1000, 16 idle cycles after each, then ACTIVE with row_idx=0.
- dv_i pulse during the first flush line -> overrun_o=1, FLUSH aborted, next real pixel written at addr 0 with wr_en=0001.
- Simultaneous hs/vs edges after row 3 -> row closed (row_idx 4), FLUSH entered; an empty hs line (no dv) -> row_idx does not advance.
- rst asserted mid-line at col 5 -> next cycle all outputs 0; dv_i ignored until a vs edge.

Source files
------------

// File: rtl/fir_linebuf_ctrl_if.sv
// Handshake bundle between the video timing source and the 5x5 FIR
// line-buffer sequencer: sync/valid inputs plus bank and window controls.
interface fir_linebuf_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              dv_i;
    logic              hs_i;
    logic              vs_i;
    logic [3:0]        wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rot_sel;
    logic              pix_valid;
    logic              pad_o;
    logic              win_valid;
    logic              top_o;
    logic              bot_o;
    logic              left_o;
    logic              right_o;
    logic [ADDR_W-1:0] row_idx;
    logic [ADDR_W-1:0] line_len;
    logic              overrun_o;

    // Video source side: drives timing, observes the sequencer.
    modport master (
        output dv_i, hs_i, vs_i,
        input  wr_en, wr_addr, rd_addr, rot_sel, pix_valid, pad_o, win_valid,
               top_o, bot_o, left_o, right_o, row_idx, line_len, overrun_o
    );

    // Sequencer side.
    modport slave (
        input  dv_i, hs_i, vs_i,
        output wr_en, wr_addr, rd_addr, rot_sel, pix_valid, pad_o, win_valid,
               top_o, bot_o, left_o, right_o, row_idx, line_len, overrun_o
    );
endinterface

// File: rtl/fir_linebuf_ctrl.sv
// Line-buffer sequencer for a 5x5 FIR: tracks line/frame geometry from the
// video syncs, steers writes into four rotating line banks, flags kernel
// borders and appends zero-padded lines after each frame so the bottom
// kernel centre rows still get produced.
module fir_linebuf_ctrl #(
    parameter int ADDR_W      = 11,
    parameter int MAX_W       = 2000,
    parameter int FLUSH_LINES = 2,
    parameter int HBLANK      = 16
) (
    input  logic              clk,
    input  logic              rst,
    fir_linebuf_ctrl_if.slave bus
);
    localparam int BLANK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam int FLUSH_W = (FLUSH_LINES > 1) ? $clog2(FLUSH_LINES) : 1;
    localparam logic [ADDR_W-1:0] ONE   = 1;
    localparam logic [ADDR_W:0]   TWO_X = 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
    state_t state, state_nx;

    logic               hs_dly, vs_dly;
    logic [ADDR_W-1:0]  row_cnt, col_cnt, len_q, h_rows;
    logic               blank, line_seen, overrun;
    logic [BLANK_W-1:0] blank_cnt;
    logic [FLUSH_W-1:0] fl_line;

    // Registered output copies
    logic [3:0]         wr_en_q;
    logic [ADDR_W-1:0]  addr_q, row_idx_q;
    logic [1:0]         rot_q;
    logic               pv_q, pad_q, win_q, top_q, bot_q, left_q, right_q;

    // Next values for the registered outputs
    logic [3:0]         wr_en_nx;
    logic [ADDR_W-1:0]  addr_nx, row_idx_nx;
    logic [1:0]         rot_nx;
    logic               pv_nx, pad_nx, win_nx, top_nx, bot_nx, left_nx, right_nx;

    logic               hs_edge, vs_edge, col_nz, line_end, blank_end, last_line;
    logic               flush_pix, act_pix;
    logic [ADDR_W-1:0]  row_closed, col_inc;

    assign hs_edge    = bus.hs_i & ~hs_dly;
    assign vs_edge    = bus.vs_i & ~vs_dly;
    assign col_nz     = (col_cnt != '0);
    // Row count after closing the current line (only if it carried pixels)
    assign row_closed = col_nz ? row_cnt + ONE : row_cnt;
    assign col_inc    = (col_cnt == ADDR_W'(MAX_W - 1)) ? col_cnt : col_cnt + ONE;
    assign line_end   = (col_cnt == len_q - ONE);
    assign blank_end  = blank && (blank_cnt == BLANK_W'(HBLANK - 1));
    assign last_line  = (fl_line == FLUSH_W'(FLUSH_LINES - 1));
    // A dv_i during flush is an overrun and suppresses the synthetic pixel
    assign flush_pix  = (state == FLUSH) && !blank && (len_q != '0) && !bus.dv_i;
    assign act_pix    = (state == ACTIVE) && bus.dv_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode: vs opens a frame, closes it into flush, flush returns to active
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vs_edge) state_nx = ACTIVE;
            ACTIVE:  if (vs_edge && (row_closed != '0)) state_nx = FLUSH;
            FLUSH:   if (bus.dv_i || (len_q == '0) || (blank_end && last_line))
                         state_nx = ACTIVE;
            default: state_nx = IDLE;
        endcase
    end

    // Sync delays, row/column counters, geometry and flush sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_dly    <= 1'b0;
            vs_dly    <= 1'b0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            len_q     <= '0;
            h_rows    <= '0;
            blank     <= 1'b0;
            blank_cnt <= '0;
            fl_line   <= '0;
            line_seen <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            hs_dly <= bus.hs_i;
            vs_dly <= bus.vs_i;
            case (state)
                IDLE: begin
                    if (vs_edge) begin
                        row_cnt   <= '0;
                        col_cnt   <= '0;
                        overrun   <= 1'b0;
                        line_seen <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vs_edge) begin
                        // vs wins over a coincident hs: close the row, then flush or restart
                        if (col_nz) len_q <= col_cnt;
                        row_cnt   <= row_closed;
                        h_rows    <= row_closed;
                        line_seen <= (row_closed != '0);
                        col_cnt   <= '0;
                        blank     <= 1'b0;
                        blank_cnt <= '0;
                        fl_line   <= '0;
                        overrun   <= 1'b0;
                    end else if (hs_edge) begin
                        if (col_nz) begin
                            len_q     <= col_cnt;
                            row_cnt   <= row_cnt + ONE;
                            line_seen <= 1'b1;
                        end
                        col_cnt <= '0;
                    end else if (bus.dv_i) begin
                        col_cnt <= col_inc;
                    end
                end
                FLUSH: begin
                    if (bus.dv_i || (len_q == '0)) begin
                        if (bus.dv_i) overrun <= 1'b1;
                        row_cnt   <= '0;
                        col_cnt   <= '0;
                        line_seen <= 1'b0;
                    end else if (!blank) begin
                        col_cnt <= col_cnt + ONE;
                        if (line_end) begin
                            blank     <= 1'b1;
                            blank_cnt <= '0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + BLANK_W'(1);
                        if (blank_end) begin
                            blank   <= 1'b0;
                            col_cnt <= '0;
                            if (last_line) begin
                                row_cnt   <= '0;
                                line_seen <= 1'b0;
                            end else begin
                                row_cnt <= row_cnt + ONE;
                                fl_line <= fl_line + FLUSH_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: bank strobes, addresses and kernel border flags per pixel
    always_comb begin
        wr_en_nx   = '0;
        addr_nx    = '0;
        rot_nx     = '0;
        row_idx_nx = row_cnt;
        pv_nx      = 1'b0;
        pad_nx     = 1'b0;
        win_nx     = 1'b0;
        top_nx     = 1'b0;
        bot_nx     = 1'b0;
        left_nx    = 1'b0;
        right_nx   = 1'b0;
        if (state != IDLE) rot_nx = row_cnt[1:0];
        if (act_pix || flush_pix) begin
            pv_nx    = 1'b1;
            pad_nx   = flush_pix;
            wr_en_nx = 4'b0001 << row_cnt[1:0];
            addr_nx  = col_cnt;
            win_nx   = (row_cnt >= ADDR_W'(2));
            top_nx   = (row_cnt < ADDR_W'(4));
            bot_nx   = flush_pix | ((h_rows != '0) && (row_cnt >= h_rows));
            left_nx  = (col_cnt < ADDR_W'(2));
            right_nx = line_seen && (({1'b0, col_cnt} + TWO_X) >= {1'b0, len_q});
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= '0;
            addr_q    <= '0;
            rot_q     <= '0;
            row_idx_q <= '0;
            pv_q      <= 1'b0;
            pad_q     <= 1'b0;
            win_q     <= 1'b0;
            top_q     <= 1'b0;
            bot_q     <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_nx;
            addr_q    <= addr_nx;
            rot_q     <= rot_nx;
            row_idx_q <= row_idx_nx;
            pv_q      <= pv_nx;
            pad_q     <= pad_nx;
            win_q     <= win_nx;
            top_q     <= top_nx;
            bot_q     <= bot_nx;
            left_q    <= left_nx;
            right_q   <= right_nx;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = addr_q;
    assign bus.rd_addr   = addr_q;
    assign bus.rot_sel   = rot_q;
    assign bus.pix_valid = pv_q;
    assign bus.pad_o     = pad_q;
    assign bus.win_valid = win_q;
    assign bus.top_o     = top_q;
    assign bus.bot_o     = bot_q;
    assign bus.left_o    = left_q;
    assign bus.right_o   = right_q;
    assign bus.row_idx   = row_idx_q;
    assign bus.line_len  = len_q;
    assign bus.overrun_o = overrun;
endmodule

// File: tb/tb_fir_linebuf_ctrl.sv
// Directed bench for fir_linebuf_ctrl: idle gating, frame writes, flush
// lines, overrun abort, coincident syncs and mid-line reset.
module tb_fir_linebuf_ctrl;
    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    fir_linebuf_ctrl_if #(.ADDR_W(ADDR_W)) vif();

    fir_linebuf_ctrl #(
        .ADDR_W(ADDR_W), .MAX_W(2000), .FLUSH_LINES(2), .HBLANK(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs for that cycle are visible on return
    task automatic cyc(input logic dv, input logic hs, input logic vs);
        vif.dv_i = dv;
        vif.hs_i = hs;
        vif.vs_i = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({vif.pix_valid, vif.wr_en, vif.wr_addr, vif.win_valid, vif.row_idx,
             vif.line_len, vif.overrun_o, vif.rot_sel, vif.pad_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got pv=%b en=%b addr=%0d row=%0d len=%0d ovr=%b want all 0",
                     vif.pix_valid, vif.wr_en, vif.wr_addr, vif.row_idx, vif.line_len, vif.overrun_o);
        end
        rst = 1'b0;
        for (int l = 0; l < 3; l++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 8; c++) begin
                cyc(1'b1, 1'b0, 1'b0);
                n_chk++;
                if ({vif.pix_valid, vif.wr_en, vif.win_valid} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL idle_ignore l%0d c%0d got pv=%b en=%b win=%b want 0",
                             l, c, vif.pix_valid, vif.wr_en, vif.win_valid);
                end
            end
        end
    endtask

    task automatic test_frame();
        logic [3:0] exp_en;
        logic [2:0] exp_fl;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            exp_en = 4'(1 << (r % 4));
            for (int c = 0; c < 8; c++) begin
                cyc(1'b1, 1'b0, 1'b0);
                n_chk++;
                if ({vif.pix_valid, vif.wr_en, vif.wr_addr, vif.rd_addr, vif.row_idx, vif.rot_sel} !==
                    {1'b1, exp_en, 11'(c), 11'(c), 11'(r), 2'(r % 4)}) begin
                    n_fail++;
                    $display("FAIL frame_write r%0d c%0d got pv=%b en=%b wa=%0d ra=%0d row=%0d rot=%0d want en=%b addr=%0d",
                             r, c, vif.pix_valid, vif.wr_en, vif.wr_addr, vif.rd_addr, vif.row_idx,
                             vif.rot_sel, exp_en, c);
                end
                exp_fl = {(r >= 2), (c < 2), (r > 0 && c >= 6)};
                n_chk++;
                if ({vif.win_valid, vif.left_o, vif.right_o} !== exp_fl) begin
                    n_fail++;
                    $display("FAIL frame_flags r%0d c%0d got win/left/right=%b want %b",
                             r, c, {vif.win_valid, vif.left_o, vif.right_o}, exp_fl);
                end
                if (r >= 2) begin
                    n_chk++;
                    if (vif.top_o !== (r < 4)) begin
                        n_fail++;
                        $display("FAIL frame_top r%0d c%0d got %b want %b", r, c, vif.top_o, (r < 4));
                    end
                end
            end
        end
        n_chk++;
        if (vif.line_len !== 11'd8) begin
            n_fail++;
            $display("FAIL frame_line_len got %0d want 8", vif.line_len);
        end
    endtask

    task automatic test_flush();
        logic [3:0] exp_en;
        cyc(1'b0, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            exp_en = (l == 0) ? 4'b0100 : 4'b1000;
            for (int c = 0; c < 8; c++) begin
                cyc(1'b0, 1'b0, 1'b0);
                n_chk++;
                if ({vif.pix_valid, vif.pad_o, vif.bot_o, vif.win_valid, vif.right_o, vif.wr_en,
                     vif.wr_addr, vif.row_idx} !==
                    {4'b1111, (c >= 6), exp_en, 11'(c), 11'(6 + l)}) begin
                    n_fail++;
                    $display("FAIL flush_pixel l%0d c%0d got pv=%b pad=%b bot=%b win=%b right=%b en=%b addr=%0d row=%0d want en=%b addr=%0d row=%0d",
                             l, c, vif.pix_valid, vif.pad_o, vif.bot_o, vif.win_valid, vif.right_o,
                             vif.wr_en, vif.wr_addr, vif.row_idx, exp_en, c, 6 + l);
                end
            end
            for (int b = 0; b < 16; b++) begin
                cyc(1'b0, 1'b0, 1'b0);
                n_chk++;
                if ({vif.pix_valid, vif.wr_en} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL flush_blank l%0d b%0d got pv=%b en=%b want 0",
                             l, b, vif.pix_valid, vif.wr_en);
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({vif.row_idx, vif.rot_sel, vif.pix_valid} !== 14'b0) begin
            n_fail++;
            $display("FAIL flush_exit got row=%0d rot=%0d pv=%b want 0 0 0",
                     vif.row_idx, vif.rot_sel, vif.pix_valid);
        end
    endtask

    task automatic test_overrun();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            repeat (8) cyc(1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n_chk++;
            if ({vif.pix_valid, vif.pad_o, vif.overrun_o, vif.wr_en, vif.wr_addr} !==
                {3'b110, 4'b1000, 11'(c)}) begin
                n_fail++;
                $display("FAIL ovr_flush c%0d got pv=%b pad=%b ovr=%b en=%b addr=%0d want 1 1 0 1000 %0d",
                         c, vif.pix_valid, vif.pad_o, vif.overrun_o, vif.wr_en, vif.wr_addr, c);
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({vif.overrun_o, vif.pix_valid, vif.wr_en} !== {2'b10, 4'b0000}) begin
            n_fail++;
            $display("FAIL ovr_drop got ovr=%b pv=%b en=%b want 1 0 0000",
                     vif.overrun_o, vif.pix_valid, vif.wr_en);
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({vif.overrun_o, vif.pix_valid, vif.pad_o, vif.wr_en, vif.wr_addr} !==
            {3'b110, 4'b0001, 11'd0}) begin
            n_fail++;
            $display("FAIL ovr_resume got ovr=%b pv=%b pad=%b en=%b addr=%0d want 1 1 0 0001 0",
                     vif.overrun_o, vif.pix_valid, vif.pad_o, vif.wr_en, vif.wr_addr);
        end
    endtask

    task automatic test_simul_hs_vs();
        do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            repeat (4) cyc(1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({vif.row_idx, vif.line_len, vif.pad_o, vif.pix_valid, vif.wr_en} !==
            {11'd4, 11'd4, 2'b11, 4'b0001}) begin
            n_fail++;
            $display("FAIL simul_close got row=%0d len=%0d pad=%b pv=%b en=%b want 4 4 1 1 0001",
                     vif.row_idx, vif.line_len, vif.pad_o, vif.pix_valid, vif.wr_en);
        end
        repeat (39) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            n_chk++;
            if ({vif.row_idx, vif.wr_en, vif.wr_addr} !== {11'd1, 4'b0010, 11'(c)}) begin
                n_fail++;
                $display("FAIL empty_line c%0d got row=%0d en=%b addr=%0d want 1 0010 %0d",
                         c, vif.row_idx, vif.wr_en, vif.wr_addr, c);
            end
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({vif.pix_valid, vif.wr_addr} !== {1'b1, 11'd4}) begin
            n_fail++;
            $display("FAIL midline_pre got pv=%b addr=%0d want 1 4", vif.pix_valid, vif.wr_addr);
        end
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({vif.pix_valid, vif.wr_en, vif.wr_addr, vif.rd_addr, vif.rot_sel, vif.pad_o,
             vif.win_valid, vif.top_o, vif.bot_o, vif.left_o, vif.right_o, vif.row_idx,
             vif.line_len, vif.overrun_o} !== '0) begin
            n_fail++;
            $display("FAIL midline_reset got pv=%b en=%b addr=%0d top=%b left=%b row=%0d len=%0d want all 0",
                     vif.pix_valid, vif.wr_en, vif.wr_addr, vif.top_o, vif.left_o, vif.row_idx, vif.line_len);
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            n_chk++;
            if ({vif.pix_valid, vif.wr_en, vif.win_valid} !== 6'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle c%0d got pv=%b en=%b win=%b want 0",
                         c, vif.pix_valid, vif.wr_en, vif.win_valid);
            end
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            n_chk++;
            if ({vif.pix_valid, vif.wr_en} !== 5'b0) begin
                n_fail++;
                $display("FAIL post_reset_hs c%0d got pv=%b en=%b want 0", c, vif.pix_valid, vif.wr_en);
            end
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({vif.pix_valid, vif.wr_en, vif.wr_addr} !== {1'b1, 4'b0001, 11'd0}) begin
            n_fail++;
            $display("FAIL post_reset_vs got pv=%b en=%b addr=%0d want 1 0001 0",
                     vif.pix_valid, vif.wr_en, vif.wr_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.dv_i = 1'b0;
        vif.hs_i = 1'b0;
        vif.vs_i = 1'b0;
        test_reset();
        test_frame();
        test_flush();
        test_overrun();
        test_simul_hs_vs();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
